sqrt_iter: RTL
==============

Name: sqrt_iter

Overview:
- Parametrised iterative integer square root using the digit-by-digit (restoring) method; produces one root bit per cycle.
- Sits in the cal_position path after the sum-of-squares stage, and feeds distance/position math downstream.
- Adds a valid/ready handshake on both sides, a remainder output and a selectable rounding mode.
- Result is exact: no seed value and no fixed iteration-count guess.

Parameters:
- IN_W, 32, radicand width; must be even and ≥ 4.
- OUT_W, IN_W/2, root width; derived, not to be overridden.
- ROUND, 0, rounding mode: 0 = floor(sqrt(x)); 1 = round-to-nearest, saturating at 2^OUT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  radicand valid.
- in_ready  out  1  block can accept a radicand; high only in IDLE.
- in_data  in  IN_W  unsigned radicand.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_root  out  OUT_W  root (floor or rounded, per ROUND).
- out_rem  out  OUT_W+1  in_data - floor_root^2, in both modes.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low at a clk edge) forces the following, overriding all else including mid-calculation:
  - state = IDLE
  - out_valid = 0, out_root = 0, out_rem = 0, busy = 0
  - all internal registers cleared
  - any in-flight operation is discarded and produces no output.
- States:
  - IDLE: in_ready = 1. On an edge with in_valid & in_ready, latch in_data into the shift register, clear the partial root and partial remainder, load bit counter = OUT_W-1, and go to CALC.
  - CALC: in_ready = 0. Each cycle:
    - rem = (rem << 2) | top two radicand bits; shift the radicand left by 2.
    - trial = (root << 2) | 1.
    - If rem ≥ trial: rem = rem - trial and root = (root << 1) | 1; otherwise root = root << 1.
    - Internal rem width is OUT_W+2 bits; no overflow is possible.
    - When the counter reaches 0 (the OUT_W-th iteration), go to FIN.
  - FIN: one cycle.
    - out_rem = rem.
    - If ROUND = 0: out_root = root.
    - If ROUND = 1: out_root = root + 1 when rem > root, else root. If root = 2^OUT_W-1, out_root saturates at 2^OUT_W-1.
    - Set out_valid = 1 and go to DONE.
  - DONE: hold out_valid, out_root and out_rem stable. On an edge with out_ready = 1: out_valid = 0, go to IDLE. in_ready stays 0 throughout DONE.
- Latency: accept edge T → out_valid high after edge T+OUT_W+1. Throughput is at most one result per OUT_W+3 cycles, including the DONE handshake cycle and the IDLE cycle.
- in_valid is ignored outside IDLE; inputs are not queued.
- out_ready is ignored when out_valid = 0.
- out_root and out_rem keep their last values after the handshake, until the next FIN.
- Radicand 0 → root 0, rem 0. Radicand 2^IN_W-1 → floor root 2^OUT_W-1, rem 2^(OUT_W+1)-2.
- Purely combinational out_ready → in_ready paths are forbidden; in_ready is decoded from state only.

Test Plan:
- Reset, then in_data = 0 → out_root = 0, out_rem = 0; out_valid asserted exactly 17 cycles after the accept edge (IN_W = 32).
- ROUND = 0, in_data = 1_000_000 → out_root = 1000, out_rem = 0; then in_data = 99 → out_root = 9, out_rem = 18.
- ROUND = 1:
  - 90 → out_root = 9 (rem 9, not > 9).
  - 91 → out_root = 10, out_rem = 10.
  - 0xFFFF_FFFF → out_root = 0xFFFF (saturated), out_rem = 0x1FFFE.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → outputs stable, in_ready stays 0, in_valid pulses ignored. Release → next radicand accepted on the following IDLE cycle.
- Assert rst_n = 0 for one cycle at iteration 5 of in_data = 12345 → no out_valid. The next accepted in_data = 144 → out_root = 12, out_rem = 0.
- Random sweep of 10k radicands with random in_valid/out_ready gaps; compare against a reference model for both ROUND values.

Source files
------------

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative unsigned integer square root, digit-by-digit
// (restoring) method, one root bit resolved per clock.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   radicand handshake (ready only while idle)
//   in_data [IN_W]      unsigned radicand
//   out_valid/out_ready result handshake (valid held until accepted)
//   out_root [OUT_W]    floor root (ROUND=0) or nearest root, saturating (ROUND=1)
//   out_rem  [OUT_W+1]  in_data - floor_root^2 in either mode
//   busy                high while calculating or holding a result
module sqrt_iter #(
  parameter int IN_W  = 32,
  parameter int OUT_W = IN_W / 2,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic [OUT_W:0]   out_rem,
  output logic             busy
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  rad_q,   rad_d;
  logic [OUT_W-1:0] root_q,  root_d;
  logic [OUT_W+1:0] rem_q,   rem_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [OUT_W-1:0] oroot_q, oroot_d;
  logic [OUT_W:0]   orem_q,  orem_d;

  // Shifted remainder and trial divisor for the current iteration. Before
  // the last iteration the partial root has at most OUT_W-1 bits, so the
  // remainder fits in OUT_W bits and dropping its top two bits loses nothing.
  logic [OUT_W+1:0] rem_sh;
  logic [OUT_W+1:0] trial;
  logic             fits;

  assign rem_sh = {rem_q[OUT_W-1:0], rad_q[IN_W-1 -: 2]};
  assign trial  = {root_q, 2'b01};
  assign fits   = (rem_sh >= trial);

  // x - r^2 > r is exactly the condition for sqrt(x) to lie closer to r+1.
  // The all-ones root cannot be incremented, so it saturates.
  function automatic logic [OUT_W-1:0] round_root(input logic [OUT_W-1:0] root,
                                                   input logic [OUT_W+1:0] rem);
    logic [OUT_W-1:0] res;
    res = root;
    if (ROUND != 0) begin
      if ((rem > {2'b00, root}) && (root != '1)) begin
        res = root + OUT_W'(1);
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    oroot_d = oroot_q;
    orem_d  = orem_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rad_d   = in_data;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CW'(OUT_W - 1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rad_d = {rad_q[IN_W-3:0], 2'b00};
        if (fits) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[OUT_W-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[OUT_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        orem_d  = rem_q[OUT_W:0];
        oroot_d = round_root(root_q, rem_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      oroot_q <= '0;
      orem_q  <= '0;
    end else begin
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      oroot_q <= oroot_d;
      orem_q  <= orem_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign out_root  = oroot_q;
  assign out_rem   = orem_q;

endmodule
